// File: rtl/clock_pkg.sv
// Shared types and constants for the six-digit clock.
// Mode encoding, field limits and per-field blink masks.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_SET_S = 2'd3
  } mode_e;

  localparam logic [4:0] HOUR_MAX    = 5'd23;
  localparam logic [5:0] MIN_SEC_MAX = 6'd59;

  localparam logic [5:0] BLINK_NONE = 6'b000000;
  localparam logic [5:0] BLINK_H    = 6'b110000;
  localparam logic [5:0] BLINK_M    = 6'b001100;
  localparam logic [5:0] BLINK_S    = 6'b000011;

  function automatic logic [5:0] blink_of(
    input mode_e m,
    input logic  ph
  );
    logic [5:0] b;
    b = BLINK_NONE;
    if (ph) begin
      unique case (m)
        MODE_SET_H: b = BLINK_H;
        MODE_SET_M: b = BLINK_M;
        MODE_SET_S: b = BLINK_S;
        default:    b = BLINK_NONE;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/time_adjust_ctrl_if.sv
// Tick/button inputs and time/display outputs of the clock controller.
// master = controller side, slave = display/stimulus side.
interface time_adjust_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic [5:0] blink_mask;
  logic       day_pulse;

  modport master (
    input  tick_1hz, btn_mode, btn_inc,
    output hour, minute, second,
    output mode, blink_mask, day_pulse
  );

  modport slave (
    output tick_1hz, btn_mode, btn_inc,
    input  hour, minute, second,
    input  mode, blink_mask, day_pulse
  );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level filter,
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Any sample agreeing with the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      pulse    <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_adjust_ctrl.sv
// Clock timekeeping plus mode/inc time-set state machine.
// Owns h/m/s, the set-mode blink phase and the rollover pulse.
module time_adjust_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic              clk_100M,
  input logic              rst_n,
  time_adjust_ctrl_if.master bus
);

  logic       mode_p;
  logic       inc_p;

  logic [4:0] hour_q, hour_n;
  logic [5:0] min_q, min_n;
  logic [5:0] sec_q, sec_n;
  mode_e      st_q, st_n;
  logic       ph_q, ph_n;
  logic [5:0] blink_q;
  logic       day_q, day_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (clk_100M),
    .rst_n (rst_n),
    .raw   (bus.btn_mode),
    .pulse (mode_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (clk_100M),
    .rst_n (rst_n),
    .raw   (bus.btn_inc),
    .pulse (inc_p)
  );

  always_comb begin
    hour_n = hour_q;
    min_n  = min_q;
    sec_n  = sec_q;
    st_n   = st_q;
    ph_n   = ph_q;
    day_n  = 1'b0;
    unique case (st_q)
      MODE_RUN: begin
        if (bus.tick_1hz) begin
          priority case (1'b1)
            sec_q != MIN_SEC_MAX: sec_n = sec_q + 6'd1;
            min_q != MIN_SEC_MAX: begin
              sec_n = '0;
              min_n = min_q + 6'd1;
            end
            hour_q != HOUR_MAX: begin
              sec_n  = '0;
              min_n  = '0;
              hour_n = hour_q + 5'd1;
            end
            default: begin
              sec_n  = '0;
              min_n  = '0;
              hour_n = '0;
              day_n  = 1'b1;
            end
          endcase
        end
      end
      MODE_SET_H: begin
        if (inc_p)
          hour_n = (hour_q >= HOUR_MAX) ? '0 : hour_q + 5'd1;
        if (bus.tick_1hz) ph_n = ~ph_q;
      end
      MODE_SET_M: begin
        if (inc_p)
          min_n = (min_q >= MIN_SEC_MAX) ? '0 : min_q + 6'd1;
        if (bus.tick_1hz) ph_n = ~ph_q;
      end
      MODE_SET_S: begin
        if (inc_p)
          sec_n = (sec_q >= MIN_SEC_MAX) ? '0 : sec_q + 6'd1;
        if (bus.tick_1hz) ph_n = ~ph_q;
      end
      default: st_n = MODE_RUN;
    endcase
    // State change wins over a same-cycle phase toggle.
    if (mode_p) begin
      st_n = mode_e'(st_q + 2'd1);
      ph_n = 1'b0;
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      st_q    <= MODE_RUN;
      ph_q    <= 1'b0;
      blink_q <= BLINK_NONE;
      day_q   <= 1'b0;
    end else begin
      hour_q  <= hour_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      st_q    <= st_n;
      ph_q    <= ph_n;
      blink_q <= blink_of(st_n, ph_n);
      day_q   <= day_n;
    end
  end

  assign bus.hour       = hour_q;
  assign bus.minute     = min_q;
  assign bus.second     = sec_q;
  assign bus.mode       = st_q;
  assign bus.blink_mask = blink_q;
  assign bus.day_pulse  = day_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Bench for time_adjust_ctrl: per-cycle reference model plus
// directed scenarios with literal expectations.
module tb_time_adjust_ctrl;

  localparam int DB = 4;

  logic clk;
  logic rst_n;

  time_adjust_ctrl_if bus ();

  time_adjust_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_100M (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference model: time as h/m/s, run mode as seconds-of-day.
  int        mh, mm, ms, mst, mph, mday;
  logic [DB:0] hm, hi;
  logic      lvm, lvi;
  logic [1:0] qm, qi;

  function automatic int exp_blink(input int st, input int ph);
    if (ph == 0) return 0;
    case (st)
      1: return 6'b110000;
      2: return 6'b001100;
      3: return 6'b000011;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mst = 0; mph = 0; mday = 0;
    hm = '0; hi = '0; lvm = 0; lvi = 0; qm = '0; qi = '0;
  endtask

  task automatic model_step();
    bit evm, evi, rm, ri;
    int tod;
    if (!rst_n) begin
      model_reset();
      return;
    end
    evm = qm[1];
    evi = qi[1];
    rm = 0;
    ri = 0;
    // A button level is accepted after DB equal synced samples.
    if (hm[DB:1] == {DB{~lvm}}) begin
      lvm = ~lvm;
      rm  = lvm;
    end
    if (hi[DB:1] == {DB{~lvi}}) begin
      lvi = ~lvi;
      ri  = lvi;
    end
    qm = {qm[0], rm};
    qi = {qi[0], ri};
    hm = {hm[DB-1:0], bus.btn_mode};
    hi = {hi[DB-1:0], bus.btn_inc};
    mday = 0;
    if (mst == 0) begin
      if (bus.tick_1hz) begin
        tod = mh * 3600 + mm * 60 + ms + 1;
        if (tod == 86400) begin
          tod  = 0;
          mday = 1;
        end
        mh = tod / 3600;
        mm = (tod / 60) % 60;
        ms = tod % 60;
      end
    end else begin
      if (evi) begin
        case (mst)
          1: mh = (mh + 1) % 24;
          2: mm = (mm + 1) % 60;
          default: ms = (ms + 1) % 60;
        endcase
      end
      if (bus.tick_1hz) mph = 1 - mph;
    end
    if (evm) begin
      mst = (mst + 1) % 4;
      mph = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("cyc_hour", bus.hour, mh);
    chk("cyc_minute", bus.minute, mm);
    chk("cyc_second", bus.second, ms);
    chk("cyc_mode", bus.mode, mst);
    chk("cyc_blink", bus.blink_mask, exp_blink(mst, mph));
    chk("cyc_day", bus.day_pulse, mday);
  end

  task automatic tick();
    @(negedge clk);
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
  endtask

  task automatic press(input bit is_inc);
    @(negedge clk);
    if (is_inc) bus.btn_inc = 1'b1;
    else bus.btn_mode = 1'b1;
    repeat (6) @(negedge clk);
    bus.btn_inc  = 1'b0;
    bus.btn_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_time(input string nm, input int h,
                          input int m, input int s);
    chk({nm, "_hour"}, bus.hour, h);
    chk({nm, "_minute"}, bus.minute, m);
    chk({nm, "_second"}, bus.second, s);
  endtask

  int n;
  int h0;
  int dcnt;
  int dzero;

  initial begin
    rst_n        = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (3) @(negedge clk);
    chk_time("rst", 0, 0, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_blink", bus.blink_mask, 0);
    chk("rst_day", bus.day_pulse, 0);
    rst_n = 1'b1;

    // 61 ticks in run
    repeat (61) tick();
    chk_time("t61", 0, 1, 1);
    chk("t61_mode", bus.mode, 0);
    chk("t61_blink", bus.blink_mask, 0);
    chk("t61_model_min", mm, 1);

    // preload 23:59:58 through the set modes
    press(0);
    repeat (23) press(1);
    press(0);
    repeat (58) press(1);
    press(0);
    repeat (57) press(1);
    press(0);
    chk_time("pre", 23, 59, 58);
    chk("pre_mode", bus.mode, 0);
    chk("pre_model_hour", mh, 23);

    // rollover
    tick();
    chk_time("t59", 23, 59, 59);
    @(negedge clk);
    bus.tick_1hz = 1'b1;
    dcnt  = 0;
    dzero = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.tick_1hz = 1'b0;
      if (bus.day_pulse) begin
        dcnt++;
        if (i == 0 && bus.hour == 0 && bus.minute == 0 &&
            bus.second == 0)
          dzero = 1;
      end
    end
    chk("day_pulse_count", dcnt, 1);
    chk("day_pulse_at_rollover", dzero, 1);
    chk_time("roll", 0, 0, 0);

    // SET_H: 25 incs wrap to 1, ticks toggle blink only
    press(0);
    chk("seth_mode", bus.mode, 1);
    repeat (25) press(1);
    chk_time("seth", 1, 0, 0);
    tick();
    chk("seth_blink_on", bus.blink_mask, 6'b110000);
    chk("seth_sec_hold", bus.second, 0);
    tick();
    chk("seth_blink_off", bus.blink_mask, 0);

    // short glitch
    @(negedge clk);
    bus.btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_hour", bus.hour, 1);

    // long hold: one increment, 8 cycles after raw edge
    h0 = bus.hour;
    @(negedge clk);
    bus.btn_inc = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.hour != h0) break;
    end
    chk("inc_latency", n, 8);
    repeat (1000 - n) @(negedge clk);
    chk("hold_hour", bus.hour, 2);
    bus.btn_inc = 1'b0;
    repeat (10) @(negedge clk);

    // SET_S: mode press with same-cycle tick drops the tick
    press(0);
    press(0);
    chk("sets_mode", bus.mode, 3);
    @(negedge clk);
    bus.btn_mode = 1'b1;
    repeat (7) @(negedge clk);
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    chk("sets_exit_mode", bus.mode, 0);
    chk("sets_exit_sec", bus.second, 0);
    repeat (10) @(negedge clk);
    tick();
    chk_time("resume", 2, 0, 1);

    // reset mid-debounce in SET_M
    press(0);
    press(0);
    chk("setm_mode", bus.mode, 2);
    @(negedge clk);
    bus.btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0);
    chk("arst_mode", bus.mode, 0);
    chk("arst_blink", bus.blink_mask, 0);
    chk("arst_day", bus.day_pulse, 0);
    bus.btn_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_time("post", 0, 0, 0);
    chk("post_mode", bus.mode, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
